// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU sequencer: FSM states, ALU select
// codes, program header layout and the legal-select helper.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    OPA  = 3'd2,
    OPB  = 3'd3,
    EXEC = 3'd4,
    CAPT = 3'd5,
    OUT  = 3'd6
  } state_e;

  localparam logic [3:0] SEL_ADD = 4'd1;
  localparam logic [3:0] SEL_SUB = 4'd3;
  localparam logic [3:0] SEL_AND = 4'd4;
  localparam logic [3:0] SEL_OR  = 4'd8;
  localparam logic [3:0] SEL_MAX = 4'd10;
  localparam logic [3:0] SEL_NOT = 4'd13;
  localparam logic [3:0] SEL_NOR = 4'd15;

  localparam int unsigned HDR_END_BIT = 31;
  localparam int unsigned HDR_SEL_LSB = 0;
  localparam int unsigned HDR_SEL_W   = 4;
  localparam int unsigned REC_LEN     = 3;

  function automatic logic sel_is_legal(input logic [3:0] sel);
    logic legal;
    case (sel)
      SEL_ADD, SEL_SUB, SEL_AND, SEL_OR, SEL_MAX, SEL_NOT, SEL_NOR: legal = 1'b1;
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu_seq_decode.sv
// Combinational header decoder: splits a program header word into the end
// flag, the ALU select and whether that select is supported.
module alu_seq_decode
  import alu_seq_pkg::*;
(
  input  logic [31:0] hdr,
  output logic        end_flag,
  output logic [3:0]  sel,
  output logic        legal
);

  logic unused_hdr_bits;
  assign unused_hdr_bits = ^hdr[HDR_END_BIT-1:HDR_SEL_LSB+HDR_SEL_W];

  // Field extraction and legality lookup
  always_comb begin
    end_flag = hdr[HDR_END_BIT];
    sel      = hdr[HDR_SEL_LSB +: HDR_SEL_W];
    legal    = sel_is_legal(sel);
  end

endmodule

// File: rtl/alu_sequencer.sv
// Fetches 3-word records (header, A, B) from a 1-cycle-latency ROM, drives an
// external ALU and hands results downstream. Optional ALU_SEQ_OPCOUNT_EN adds op_count.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned ROM_AW     = 8,
  parameter int unsigned START_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [31:0]       rom_data,
  output logic [31:0]       alu_a,
  output logic [31:0]       alu_b,
  output logic [3:0]        alu_select,
  input  logic [31:0]       alu_out,
  input  logic              alu_carry,
  output logic [31:0]       result,
  output logic              result_carry,
  output logic              result_valid,
  input  logic              result_ready,
  output logic              busy,
  output logic              done,
  output logic              illegal
`ifdef ALU_SEQ_OPCOUNT_EN
  , output logic [15:0]     op_count
`endif
);

  localparam logic [ROM_AW-1:0] START_PC = ROM_AW'(START_ADDR);
  localparam logic [ROM_AW-1:0] PC_ONE   = ROM_AW'(1);

  state_e            state_q, state_d;
  logic [ROM_AW-1:0] pc_q, pc_d;
  logic              end_q, end_d, legal_q, legal_d;
  logic [3:0]        sel_q, sel_d, alu_select_q, alu_select_d;
  logic [31:0]       alu_a_q, alu_a_d, alu_b_q, alu_b_d, result_q, result_d;
  logic              result_carry_q, result_carry_d, result_valid_q, result_valid_d;
  logic              busy_q, busy_d, done_q, done_d, illegal_q, illegal_d;
  logic              dec_end_s, dec_legal_s;
  logic [3:0]        dec_sel_s;
  logic              start_acc_s, handshake_s;

  alu_seq_decode u_decode (
    .hdr      (rom_data),
    .end_flag (dec_end_s),
    .sel      (dec_sel_s),
    .legal    (dec_legal_s)
  );

  // A start coinciding with the done pulse is dropped so it cannot re-trigger
  assign start_acc_s = (state_q == IDLE) && start && !done_q;
  assign handshake_s = (state_q == OUT) && result_valid_q && result_ready;

  // Next-state and next-output computation
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    end_d          = end_q;
    legal_d        = legal_q;
    sel_d          = sel_q;
    alu_a_d        = alu_a_q;
    alu_b_d        = alu_b_q;
    alu_select_d   = alu_select_q;
    result_d       = result_q;
    result_carry_d = result_carry_q;
    result_valid_d = result_valid_q;
    done_d         = 1'b0;
    illegal_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_acc_s) begin
          pc_d    = START_PC;
          state_d = HDR;
        end else begin
          state_d = IDLE;
        end
      end
      HDR: begin
        pc_d    = pc_q + PC_ONE;
        state_d = OPA;
      end
      OPA: begin
        end_d   = dec_end_s;
        sel_d   = dec_sel_s;
        legal_d = dec_legal_s;
        pc_d    = pc_q + PC_ONE;
        state_d = OPB;
      end
      OPB: begin
        alu_a_d = rom_data;
        pc_d    = pc_q + PC_ONE;
        state_d = EXEC;
      end
      EXEC: begin
        alu_b_d      = rom_data;
        alu_select_d = sel_q;
        state_d      = CAPT;
      end
      CAPT: begin
        if (legal_q) begin
          result_d       = alu_out;
          result_carry_d = alu_carry;
          result_valid_d = 1'b1;
          state_d        = OUT;
        end else begin
          illegal_d = 1'b1;
          done_d    = end_q;
          state_d   = end_q ? IDLE : HDR;
        end
      end
      OUT: begin
        if (handshake_s) begin
          result_valid_d = 1'b0;
          done_d         = end_q;
          state_d        = end_q ? IDLE : HDR;
        end else begin
          state_d = OUT;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      pc_q           <= START_PC;
      end_q          <= 1'b0;
      legal_q        <= 1'b0;
      sel_q          <= 4'd0;
      alu_a_q        <= 32'd0;
      alu_b_q        <= 32'd0;
      alu_select_q   <= 4'd0;
      result_q       <= 32'd0;
      result_carry_q <= 1'b0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      illegal_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      end_q          <= end_d;
      legal_q        <= legal_d;
      sel_q          <= sel_d;
      alu_a_q        <= alu_a_d;
      alu_b_q        <= alu_b_d;
      alu_select_q   <= alu_select_d;
      result_q       <= result_d;
      result_carry_q <= result_carry_d;
      result_valid_q <= result_valid_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      illegal_q      <= illegal_d;
    end
  end

  assign rom_addr     = pc_q;
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_select   = alu_select_q;
  assign result       = result_q;
  assign result_carry = result_carry_q;
  assign result_valid = result_valid_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign illegal      = illegal_q;

`ifdef ALU_SEQ_OPCOUNT_EN
  logic [15:0] op_count_q, op_count_d;

  // Handshaken-result counter, saturating, cleared by an accepted start
  always_comb begin
    if (start_acc_s) begin
      op_count_d = 16'h0000;
    end else if (handshake_s && (op_count_q != 16'hFFFF)) begin
      op_count_d = op_count_q + 16'd1;
    end else begin
      op_count_d = op_count_q;
    end
  end

  // Counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count_q <= 16'h0000;
    end else begin
      op_count_q <= op_count_d;
    end
  end

  assign op_count = op_count_q;
`endif

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter ROM_AW, default 8, ROM address width.
REQ-002 SHALL have parameter START_ADDR, default 0, first header address loaded on start.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  begin program at START_ADDR (sampled in IDLE only).
REQ-006 SHALL have port rom_addr  output  ROM_AW  ROM read address; ROM returns data exactly 1 cycle later.
REQ-007 SHALL have port rom_data  input  32  ROM read data.
REQ-008 SHALL have ports alu_a, alu_b  output  32 each  registered ALU operands.
REQ-009 SHALL have port alu_select  output  4  registered ALU opcode.
REQ-010 SHALL have ports alu_out  input  32 and alu_carry  input  1  combinational ALU result.
REQ-011 SHALL have ports result  output  32 and result_carry  output  1  captured ALU result.
REQ-012 SHALL have ports result_valid  output  1 and result_ready  input  1  downstream handshake.
REQ-013 SHALL have ports busy, done, illegal  output  1 each  status; done and illegal are single-cycle pulses.

Function
REQ-014 SHALL read a program of 3-word records: header (bit31 = end flag, bits3:0 = select), operand A, operand B.
REQ-015 SHALL drive rom_addr = pc combinationally; pc increments by 1 per fetch cycle and wraps from 2^ROM_AW-1 to 0.
REQ-016 SHALL use FSM states IDLE, HDR, OPA, OPB, EXEC, CAPT, OUT.
REQ-017 IDLE: start=1 loads pc=START_ADDR, goes to HDR; busy=0 only in IDLE.
REQ-018 HDR presents header address; OPA captures header, presents A address; OPB captures alu_a, presents B address; EXEC captures alu_b and alu_select.
REQ-019 CAPT: legal select (1,3,4,8,10,13,15) captures alu_out/alu_carry into result/result_carry, sets result_valid, goes to OUT.
REQ-020 CAPT: illegal select pulses illegal for 1 cycle, leaves result/result_valid unchanged, and continues as if OUT completed.
REQ-021 OUT: holds result, result_carry, result_valid stable until result_valid&&result_ready; then clears result_valid.
REQ-022 After a completed record: end flag=1 pulses done and returns to IDLE; else goes to HDR with pc at next record.
REQ-023 Latency: start in cycle 0 -> result_valid=1 in cycle 6 for a legal first record; ready held high gives one record per 6 cycles.
REQ-024 start while busy SHALL be ignored; start in the same cycle done pulses SHALL be ignored.
REQ-025 Records straddling the address wrap SHALL fetch correctly across the wrap.

Reset
REQ-026 rst=1 at any time SHALL force IDLE, pc=START_ADDR, and all outputs to 0, including mid-record and while result_valid=1.

Configuration
REQ-027 With ALU_SEQ_OPCOUNT_EN defined, SHALL add output op_count (16 bits): counts handshaken results, reset to 0, cleared on accepted start, saturates at 16'hFFFF.
REQ-028 Without ALU_SEQ_OPCOUNT_EN, op_count and its counter SHALL be absent; all other behaviour identical.

Structure
REQ-029 Package alu_seq_pkg SHALL hold the state enum, select constants (SEL_ADD=1, SEL_SUB=3, SEL_AND=4, SEL_OR=8, SEL_MAX=10, SEL_NOT=13, SEL_NOR=15), header field positions, and the record length constant 3.
REQ-030 A single combinational sub-module alu_seq_decode SHALL split the header into end flag, select, and legal bit.
REQ-031 The ALU SHALL be external; this block instantiates no arithmetic.

Verification
REQ-032 ROM[0..2]={32'h8000_0001, 5, 7}, start, ready=1 -> cycle 6 result=12, result_valid=1; done pulses after handshake.
REQ-033 Two records (AND 0xF0F0 & 0xFF00, then end-flagged OR 1|2) with ready=0 for 4 cycles -> first result 0xF000 held stable 4 cycles, then second result 3.
REQ-034 Header select=2 with end flag -> illegal pulses once, result_valid never asserts, done pulses, IDLE.
REQ-035 START_ADDR=254, ROM_AW=8, record at 254,255,0 -> operands from 255 and 0 fetched; result correct.
REQ-036 rst asserted in OPB and again in OUT -> next cycle all outputs 0, state IDLE; fresh start reruns the program correctly.
REQ-037 With ALU_SEQ_OPCOUNT_EN, 3 legal records + 1 illegal -> op_count=3; second start clears it to 0.
